// File: rtl/parity_gen_chk.sv
// rtl/parity_gen_chk.sv - parity generator/checker with a one-stage registered valid/ready stream
module parity_gen_chk #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr
);

    localparam logic ODD_BIT = (ODD != 0);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W:0]   out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              in_fire;
    logic              exp_par;
    logic              mism;

    // The slot frees up in the same cycle downstream takes the held beat.
    assign in_ready = !out_valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign exp_par  = (^in_data) ^ ODD_BIT;
    assign mism     = in_mode & (in_par != exp_par);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;

        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = {in_data, (in_mode ? in_par : exp_par)};
            out_err_d   = mism;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over a mismatch accepted in the same cycle.
        if (clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end else if (in_fire & mism) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// tb/tb_parity_gen_chk.sv - directed self-checking bench for parity_gen_chk
module tb_parity_gen_chk;

    logic       clk;
    logic       n_rst;
    logic       in_valid;
    logic       in_mode;
    logic [7:0] in_data;
    logic       in_par;
    logic       out_ready;
    logic       clr;

    logic       e_in_ready, e_out_valid, e_out_err, e_err_sticky;
    logic [8:0] e_out_data;
    logic [1:0] e_err_cnt;

    logic       o_in_ready, o_out_valid, o_out_err, o_err_sticky;
    logic [8:0] o_out_data;
    logic [7:0] o_err_cnt;

    logic       w_in_ready, w_out_valid, w_out_err, w_err_sticky;
    logic [1:0] w_out_data;
    logic [7:0] w_err_cnt;

    int n_cmp;
    int n_bad;

    parity_gen_chk #(.DATA_W(8), .ODD(0), .CNT_W(2)) u_even (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(e_in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_par(in_par),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_data(e_out_data),
        .out_err(e_out_err), .err_sticky(e_err_sticky), .err_cnt(e_err_cnt),
        .clr(clr)
    );

    parity_gen_chk #(.DATA_W(8), .ODD(1), .CNT_W(8)) u_odd (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(o_in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_par(in_par),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
        .out_err(o_out_err), .err_sticky(o_err_sticky), .err_cnt(o_err_cnt),
        .clr(clr)
    );

    parity_gen_chk #(.DATA_W(1), .ODD(0), .CNT_W(8)) u_w1 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_mode(in_mode),
        .in_data(in_data[0]), .in_par(in_par),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_err(w_out_err), .err_sticky(w_err_sticky), .err_cnt(w_err_cnt),
        .clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic mode, input logic [7:0] data, input logic par);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_par   = par;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = 8'h00;
        in_par    = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;

        #2;
        check("rst_out_valid", 32'(e_out_valid), 32'h0);
        check("rst_out_data",  32'(e_out_data), 32'h0);
        check("rst_out_err",   32'(e_out_err), 32'h0);
        check("rst_err_cnt",   32'(e_err_cnt), 32'h0);
        check("rst_sticky",    32'(e_err_sticky), 32'h0);
        check("rst_in_ready",  32'(e_in_ready), 32'h1);
        @(negedge clk);
        n_rst = 1'b1;
        step();

        // Generate beats, back to back
        beat(1'b0, 8'hA5, 1'b0);
        step();
        check("gen_a5_valid", 32'(e_out_valid), 32'h1);
        check("gen_a5_even",  32'(e_out_data), 32'h14A);
        check("gen_a5_err",   32'(e_out_err), 32'h0);
        check("gen_a5_odd",   32'(o_out_data), 32'h14B);
        check("gen_a5_w1",    32'(w_out_data), 32'h3);
        beat(1'b0, 8'h01, 1'b0);
        step();
        check("gen_01_even", 32'(e_out_data), 32'h003);
        check("gen_01_odd",  32'(o_out_data), 32'h002);
        beat(1'b0, 8'h00, 1'b0);
        step();
        check("gen_00_even", 32'(e_out_data), 32'h000);
        check("gen_00_odd",  32'(o_out_data), 32'h001);
        check("gen_00_w1",   32'(w_out_data), 32'h0);

        // Check beats, mode switches with no bubble
        beat(1'b1, 8'h3C, 1'b1);
        step();
        check("chk_mis_data",   32'(e_out_data), 32'h079);
        check("chk_mis_err",    32'(e_out_err), 32'h1);
        check("chk_mis_cnt",    32'(e_err_cnt), 32'h1);
        check("chk_mis_sticky", 32'(e_err_sticky), 32'h1);
        check("chk_odd_ok_err", 32'(o_out_err), 32'h0);
        check("chk_odd_ok_cnt", 32'(o_err_cnt), 32'h0);
        beat(1'b1, 8'h3C, 1'b0);
        step();
        check("chk_ok_data",    32'(e_out_data), 32'h078);
        check("chk_ok_err",     32'(e_out_err), 32'h0);
        check("chk_ok_cnt",     32'(e_err_cnt), 32'h1);
        check("chk_ok_sticky",  32'(e_err_sticky), 32'h1);
        check("chk_odd_mis",    32'(o_out_err), 32'h1);
        check("chk_odd_cnt",    32'(o_err_cnt), 32'h1);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(e_out_valid), 32'h0);

        // Backpressure: 3 stalled cycles, then drain 4 beats at full rate
        out_ready = 1'b0;
        beat(1'b0, 8'h13, 1'b0);
        step();
        check("bp_first_valid", 32'(e_out_valid), 32'h1);
        check("bp_first_data",  32'(e_out_data), 32'h027);
        beat(1'b0, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 32'(e_in_ready), 32'h0);
            check("bp_data_hold",    32'(e_out_data), 32'h027);
            check("bp_valid_hold",   32'(e_out_valid), 32'h1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 32'(e_in_ready), 32'h1);
        check("bp_head_data", 32'(e_out_data), 32'h027);
        step();
        check("bp_b2_data", 32'(e_out_data), 32'h044);
        beat(1'b0, 8'h37, 1'b0);
        step();
        check("bp_b3_data", 32'(e_out_data), 32'h06F);
        beat(1'b0, 8'h44, 1'b0);
        step();
        check("bp_b4_data",  32'(e_out_data), 32'h088);
        check("bp_b4_valid", 32'(e_out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        check("bp_end_valid", 32'(e_out_valid), 32'h0);

        // Saturation and clear on the CNT_W=2 instance
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("idle_clr_cnt",    32'(e_err_cnt), 32'h0);
        check("idle_clr_sticky", 32'(e_err_sticky), 32'h0);
        check("idle_clr_valid",  32'(e_out_valid), 32'h0);
        beat(1'b1, 8'h3C, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sat_cnt", 32'(e_err_cnt), (i < 3) ? i : 3);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_pri_cnt",    32'(e_err_cnt), 32'h0);
        check("clr_pri_sticky", 32'(e_err_sticky), 32'h0);
        check("clr_pri_err",    32'(e_out_err), 32'h1);
        step();
        check("post_clr_cnt",    32'(e_err_cnt), 32'h1);
        check("post_clr_sticky", 32'(e_err_sticky), 32'h1);
        step();
        check("pre_rst_cnt",   32'(e_err_cnt), 32'h2);
        check("pre_rst_valid", 32'(e_out_valid), 32'h1);

        // Asynchronous reset mid-cycle
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_valid",  32'(e_out_valid), 32'h0);
        check("arst_data",   32'(e_out_data), 32'h0);
        check("arst_cnt",    32'(e_err_cnt), 32'h0);
        check("arst_sticky", 32'(e_err_sticky), 32'h0);
        check("arst_odd_cnt", 32'(o_err_cnt), 32'h0);
        in_valid = 1'b0;
        #2;
        n_rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(e_in_ready), 32'h1);
        beat(1'b0, 8'hFF, 1'b0);
        step();
        check("rel_ff_even",  32'(e_out_data), 32'h1FE);
        check("rel_ff_odd",   32'(o_out_data), 32'h1FF);
        check("rel_ff_valid", 32'(e_out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        check("rel_end_valid", 32'(e_out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
